// File: rtl/cpu_loader_pkg.sv
// rtl/cpu_loader_pkg.sv - state encoding and address strides for cpu_loader_ctrl
package cpu_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_I   = 3'd1,
    ST_LOAD_D   = 3'd2,
    ST_RUN      = 3'd3,
    ST_DUMP_RD  = 3'd4,
    ST_DUMP_CAP = 3'd5,
    ST_DUMP_OUT = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  localparam int IMEM_STRIDE = 4;
  localparam int DMEM_STRIDE = 8;

  // First phase of the remaining session that has work to do.
  function automatic state_t pick_phase(input logic has_i, input logic has_d,
                                        input logic has_run, input state_t after_run);
    if (has_i)        return ST_LOAD_I;
    else if (has_d)   return ST_LOAD_D;
    else if (has_run) return ST_RUN;
    else              return after_run;
  endfunction

endpackage

// File: rtl/cpu_loader_ctrl.sv
// rtl/cpu_loader_ctrl.sv - load/run/dump sequencer for the cpu; dump path built only with CPU_LOADER_DUMP_EN
module cpu_loader_ctrl
  import cpu_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024,
  parameter int CYC_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_start,
  input  logic [9:0]       i_imem_len,
  input  logic [10:0]      i_dmem_len,
  input  logic [CYC_W-1:0] i_run_cycles,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [63:0]      i_s_data,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [63:0]      o_m_data,
  output logic             o_cpu_arst_n,
  output logic             o_cpu_enable,
  output logic [63:0]      o_addr_ext,
  output logic             o_wen_ext,
  output logic             o_ren_ext,
  output logic [31:0]      o_wdata_ext,
  output logic [63:0]      o_addr_ext_2,
  output logic             o_wen_ext_2,
  output logic             o_ren_ext_2,
  output logic [63:0]      o_wdata_ext_2,
  input  logic [63:0]      i_rdata_ext_2,
  output logic             o_busy,
  output logic             o_done,
  output logic [2:0]       o_phase
);

  localparam logic [10:0]      IMEM_CAP = 11'(IMEM_WORDS);
  localparam logic [10:0]      DMEM_CAP = 11'(DMEM_WORDS);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

  state_t           r_state;
  state_t           w_next;
  state_t           w_after_run;
  logic [10:0]      r_imem_len;
  logic [10:0]      r_dmem_len;
  logic [10:0]      r_idx;
  logic [CYC_W-1:0] r_run_cycles;
  logic [CYC_W-1:0] r_cyc;
  logic [10:0]      w_imem_c;
  logic [10:0]      w_dmem_c;
  logic             w_latch;
  logic             w_idx_inc;
  logic             w_idx_clr;
  logic             w_cyc_inc;
  logic             w_last_i;
  logic             w_last_d;
  logic             w_run_end;
  logic             w_in_load;
  logic [63:0]      w_dmem_addr;
`ifdef CPU_LOADER_DUMP_EN
  logic             w_cap;
  logic [63:0]      r_m_data;
`else
  logic             w_unused_dump;
`endif

  assign w_imem_c  = ({1'b0, i_imem_len} > IMEM_CAP) ? IMEM_CAP : {1'b0, i_imem_len};
  assign w_dmem_c  = (i_dmem_len > DMEM_CAP) ? DMEM_CAP : i_dmem_len;
  assign w_last_i  = (r_idx == r_imem_len - 11'd1);
  assign w_last_d  = (r_idx == r_dmem_len - 11'd1);
  assign w_run_end = (r_cyc == r_run_cycles - CYC_ONE);

`ifdef CPU_LOADER_DUMP_EN
  assign w_after_run = (r_dmem_len != '0) ? ST_DUMP_RD : ST_DONE;
`else
  assign w_after_run = ST_DONE;
`endif

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state      <= ST_IDLE;
      r_imem_len   <= '0;
      r_dmem_len   <= '0;
      r_run_cycles <= '0;
      r_cyc        <= '0;
      r_idx        <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_imem_len   <= w_imem_c;
        r_dmem_len   <= w_dmem_c;
        r_run_cycles <= i_run_cycles;
        r_cyc        <= '0;
      end else if (w_cyc_inc) begin
        r_cyc <= r_cyc + CYC_ONE;
      end
      // Clear wins so the index is zero on entry to each new phase.
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + 11'd1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_idx_inc = 1'b0;
    w_idx_clr = 1'b0;
    w_cyc_inc = 1'b0;
`ifdef CPU_LOADER_DUMP_EN
    w_cap     = 1'b0;
`endif
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_latch   = 1'b1;
          w_idx_clr = 1'b1;
          w_next    = pick_phase(w_imem_c != '0, w_dmem_c != '0, i_run_cycles != '0, ST_DONE);
        end
      end
      ST_LOAD_I: begin
        if (i_s_valid) begin
          w_idx_inc = 1'b1;
          if (w_last_i) begin
            w_idx_clr = 1'b1;
            w_next    = pick_phase(1'b0, r_dmem_len != '0, r_run_cycles != '0, w_after_run);
          end
        end
      end
      ST_LOAD_D: begin
        if (i_s_valid) begin
          w_idx_inc = 1'b1;
          if (w_last_d) begin
            w_idx_clr = 1'b1;
            w_next    = pick_phase(1'b0, 1'b0, r_run_cycles != '0, w_after_run);
          end
        end
      end
      ST_RUN: begin
        w_cyc_inc = 1'b1;
        if (w_run_end) w_next = w_after_run;
      end
`ifdef CPU_LOADER_DUMP_EN
      ST_DUMP_RD:  w_next = ST_DUMP_CAP;
      ST_DUMP_CAP: begin
        w_cap  = 1'b1;
        w_next = ST_DUMP_OUT;
      end
      ST_DUMP_OUT: begin
        if (i_m_ready) begin
          w_idx_inc = 1'b1;
          if (w_last_d) begin
            w_idx_clr = 1'b1;
            w_next    = ST_DONE;
          end else begin
            w_next = ST_DUMP_RD;
          end
        end
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef CPU_LOADER_DUMP_EN
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst)     r_m_data <= '0;
    else if (w_cap) r_m_data <= i_rdata_ext_2;
  end

  assign o_m_valid    = (r_state == ST_DUMP_OUT);
  assign o_m_data     = r_m_data;
  assign o_ren_ext_2  = (r_state == ST_DUMP_RD);
  assign o_addr_ext_2 = ((r_state == ST_LOAD_D) || (r_state == ST_DUMP_RD)) ? w_dmem_addr : '0;
`else
  assign w_unused_dump = ^{i_m_ready, i_rdata_ext_2};
  assign o_m_valid     = 1'b0;
  assign o_m_data      = '0;
  assign o_ren_ext_2   = 1'b0;
  assign o_addr_ext_2  = (r_state == ST_LOAD_D) ? w_dmem_addr : '0;
`endif

  assign w_in_load     = (r_state == ST_LOAD_I) || (r_state == ST_LOAD_D);
  assign w_dmem_addr   = 64'(r_idx) * 64'(DMEM_STRIDE);
  assign o_s_ready     = w_in_load;
  assign o_wen_ext     = (r_state == ST_LOAD_I) && i_s_valid;
  assign o_addr_ext    = (r_state == ST_LOAD_I) ? 64'(r_idx) * 64'(IMEM_STRIDE) : '0;
  assign o_wdata_ext   = o_wen_ext ? i_s_data[31:0] : '0;
  assign o_ren_ext     = 1'b0;
  assign o_wen_ext_2   = (r_state == ST_LOAD_D) && i_s_valid;
  assign o_wdata_ext_2 = o_wen_ext_2 ? i_s_data : '0;
  // Core is held in reset until loading is complete, then left running/parked.
  assign o_cpu_arst_n  = !((r_state == ST_IDLE) || w_in_load);
  assign o_cpu_enable  = (r_state == ST_RUN);
  assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_done        = (r_state == ST_DONE);
  assign o_phase       = r_state;

endmodule

// File: doc/cpu_loader_ctrl.md
# cpu_loader_ctrl

Host-side sequencer for the pipelined 64-bit RISC-V `cpu`. It streams a program into instruction memory and an initial image into data memory through the `cpu` external memory ports. It then releases the core from reset and runs it with `enable` high for a programmed number of cycles. Finally it reads back the data memory image as an output stream. It sits between the testbench/host interface and the `cpu` top, and is the only driver of `cpu`'s `arst_n`, `enable`, `*_ext` and `*_ext_2` ports.

## Interface
Parameters:
- IMEM_WORDS, 512, instruction memory depth in 32-bit words
- DMEM_WORDS, 1024, data memory depth in 64-bit words
- CYC_W, 32, width of run-cycle counter

Ports:
- clk  in  1  clock
- arst  in  1  reset; one clock; reset is asynchronous and active-high
- start  in  1  begin a session; sampled only in IDLE or DONE
- imem_len  in  10  instruction words to load; sampled at start
- dmem_len  in  11  data words to load/dump; sampled at start
- run_cycles  in  CYC_W  cycles with enable high; sampled at start
- s_valid / s_ready  in / out  1  load stream handshake
- s_data  in  64  load word; imem uses [31:0]
- m_valid / m_ready  out / in  1  dump stream handshake
- m_data  out  64  dumped dmem word
- cpu_arst_n  out  1  drives `cpu.arst_n`
- cpu_enable  out  1  drives `cpu.enable`
- addr_ext, wen_ext, ren_ext, wdata_ext  out  64/1/1/32  imem external port
- addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2  out  64/1/1/64  dmem external port
- rdata_ext_2  in  64  dmem external read data
- busy, done  out  1  status
- phase  out  3  current state encoding

## Operation
- States: IDLE(0), LOAD_I(1), LOAD_D(2), RUN(3), DUMP_RD(4), DUMP_CAP(5), DUMP_OUT(6), DONE(7). `phase` equals the state.
- IDLE/DONE on start:
  - Latch lengths. Clamp: imem_len to IMEM_WORDS, dmem_len to DMEM_WORDS.
  - Clear index and cycle counter.
  - Go to the first non-empty of LOAD_I, LOAD_D, RUN, else DONE.
- LOAD_I:
  - s_ready=1.
  - Each handshake: wen_ext=1, addr_ext=idx*4, wdata_ext=s_data[31:0], idx++.
  - After word imem_len-1, go to LOAD_D (skip if dmem_len=0).
- LOAD_D: same behaviour on the dmem port, with addr_ext_2=idx*8 and wdata_ext_2=s_data.
- cpu_arst_n=0 in IDLE, LOAD_I and LOAD_D; 1 from RUN onward. The PC restarts at 0 each session.
- RUN:
  - cpu_enable=1. The counter increments each cycle.
  - After exactly run_cycles cycles with enable high, go to DUMP_RD if dmem_len>0, else DONE.
  - run_cycles=0 skips RUN entirely.
- Dump loop:
  - DUMP_RD: ren_ext_2=1, addr_ext_2=idx*8.
  - DUMP_CAP: capture rdata_ext_2 into m_data.
  - DUMP_OUT: m_valid=1 until m_ready. Then idx++, and return to DUMP_RD or go to DONE after the last word.
- DONE: done=1, cpu_arst_n stays 1, cpu_enable=0.
- busy=1 in states 1–6. start is ignored while busy. s_ready=0 outside load states.
- All unused ext outputs are 0. ren_ext is always 0.

## Timing
- Reset values: state IDLE, all counters 0. Every output 0 except cpu_arst_n=0.
- Load path is combinational from the handshake: the memory write occurs in the same cycle as s_valid&s_ready. Throughput is 1 word/cycle.
- Dmem read latency is 1 cycle. Dump throughput is 3 cycles/word with m_ready held high.
- m_data and m_valid are registered and held stable while m_valid=1 && m_ready=0.
- Start→first s_ready is 1 cycle. Last load handshake→first cpu_enable is 1 cycle.
- arst mid-session: immediate return to IDLE and the core is held in reset. Memory contents are undefined to the controller.

## Configuration
- CPU_LOADER_DUMP_EN defined: dump states are present as above.
- Not defined:
  - RUN (or the skip path) goes directly to DONE.
  - m_valid and m_data are tied 0.
  - The ren_ext_2 read logic is not compiled.
  - States 4–6 never appear.

## Structure
- Package `cpu_loader_pkg` holds:
  - the state enum (3-bit, encodings above)
  - IMEM_STRIDE=4 and DMEM_STRIDE=8 byte-address constants
- Single module; no sub-module. Reuse of the active-low register cell is not permitted (reset polarity differs).

## Test plan
- Reset asserted mid-LOAD_D → phase=0, cpu_arst_n=0, s_ready=0 within the same cycle.
- imem_len=3, dmem_len=0, run_cycles=5, s_valid always high:
  - wen_ext pulses at addr 0, 4, 8.
  - cpu_enable is high exactly 5 cycles.
  - done=1, m_valid never asserts.
- imem_len=1, dmem_len=2, load D words 0xA, 0xB, run_cycles=0, m_ready=1:
  - m_data=0xA then 0xB, each output 3 cycles apart.
  - done follows.
- Dump backpressure: m_ready low for 4 cycles on word 0 → m_data stable, no second ren_ext_2 until the handshake.
- imem_len=600 → exactly 512 writes, last addr_ext=2044.
- start pulsed during RUN → ignored; run length unchanged; second start in DONE begins a new session with cpu_arst_n=0.
